// File: rtl/vending_pkg.sv
// vending_pkg: shared state encoding, coin values and price conversion
package vending_pkg;
  typedef enum logic [1:0] {IDLE, VEND, CHANGE} state_e;
  localparam int NICKEL_V  = 1;
  localparam int DIME_V    = 2;
  localparam int QUARTER_V = 5;
  function automatic int price_to_nickels(input int cents);
    return cents / 5;
  endfunction
endpackage

// File: rtl/change_dispenser.sv
// change_dispenser: greedy one-coin-per-cycle payout of a loaded nickel count
module change_dispenser
  import vending_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic [CW-1:0] load_i,
  output logic          nickel_o,
  output logic          dime_o,
  output logic          quarter_o,
  output logic          done_o,
  output logic [CW-1:0] rem_o
);
  logic [CW-1:0] cnt_q, step;
  logic          active_q, nickel_q, dime_q, quarter_q;
  assign step = cnt_q >= CW'(QUARTER_V) ? CW'(QUARTER_V) :
                cnt_q >= CW'(DIME_V)    ? CW'(DIME_V)    : CW'(NICKEL_V);
  assign rem_o     = cnt_q - step;
  assign done_o    = active_q && rem_o == '0;
  assign nickel_o  = nickel_q;
  assign dime_o    = dime_q;
  assign quarter_o = quarter_q;
  // load on start, then pay one coin per edge until the count is exhausted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= 1'b0;
      nickel_q  <= 1'b0;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
    end else begin
      nickel_q  <= active_q && step == CW'(NICKEL_V);
      dime_q    <= active_q && step == CW'(DIME_V);
      quarter_q <= active_q && step == CW'(QUARTER_V);
      if (start_i) begin
        cnt_q    <= load_i;
        active_q <= 1'b1;
      end else if (active_q) begin
        cnt_q    <= rem_o;
        active_q <= !done_o;
      end
    end
  end
endmodule

// File: rtl/vending_machine_param.sv
// vending_machine_param: credit accumulation, vend handshake, stock tracking and refund
module vending_machine_param
  import vending_pkg::*;
#(
  parameter  int PRICE_CENTS = 15,
  parameter  int STOCK_MAX   = 8,
  localparam int PRICE_N     = price_to_nickels(PRICE_CENTS),
  localparam int CW          = $clog2(PRICE_N + 5),
  localparam int SW          = $clog2(STOCK_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          nickel_in,
  input  logic          dime_in,
  input  logic          quarter_in,
  input  logic          coin_return_in,
  input  logic          thanks_in,
  input  logic          restock_in,
  output logic          candy_out,
  output logic          nickel_out,
  output logic          dime_out,
  output logic          quarter_out,
  output logic          busy,
  output logic          sold_out,
  output logic [CW-1:0] credit,
  output logic [SW-1:0] stock
);
  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d, coin_v, sum, load, rem;
  logic [SW-1:0] stock_q, stock_d;
  logic          candy_q, candy_d, busy_q, sold_q, start, done, coin_ok;
  assign coin_ok = $onehot({nickel_in, dime_in, quarter_in}) && !sold_q;
  assign coin_v  = !coin_ok  ? '0 :
                   nickel_in ? CW'(NICKEL_V) :
                   dime_in   ? CW'(DIME_V)   : CW'(QUARTER_V);
  assign sum       = credit_q + coin_v;
  assign candy_out = candy_q;
  assign busy      = busy_q;
  assign sold_out  = sold_q;
  assign credit    = credit_q;
  assign stock     = stock_q;
  change_dispenser #(.CW(CW)) u_disp (
    .clk      (clk),
    .rst      (reset),
    .start_i  (start),
    .load_i   (load),
    .nickel_o (nickel_out),
    .dime_o   (dime_out),
    .quarter_o(quarter_out),
    .done_o   (done),
    .rem_o    (rem)
  );
  // next state: refund beats vend in IDLE; credit tracks the payout in CHANGE
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    stock_d  = stock_q;
    candy_d  = candy_q;
    start    = 1'b0;
    load     = credit_q;
    case (state_q)
      IDLE: begin
        if (restock_in) stock_d = SW'(STOCK_MAX);
        if (coin_return_in && sum != '0) begin
          start    = 1'b1;
          load     = sum;
          credit_d = sum;
          state_d  = CHANGE;
        end else if (coin_ok && sum >= CW'(PRICE_N)) begin
          credit_d = sum - CW'(PRICE_N);
          stock_d  = stock_d - SW'(1);
          candy_d  = 1'b1;
          state_d  = VEND;
        end else begin
          credit_d = sum;
        end
      end
      VEND: begin
        if (thanks_in) begin
          candy_d = 1'b0;
          start   = credit_q != '0;
          state_d = credit_q != '0 ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        credit_d = rem;
        state_d  = done ? IDLE : CHANGE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      stock_q  <= SW'(STOCK_MAX);
      candy_q  <= 1'b0;
      busy_q   <= 1'b0;
      sold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      stock_q  <= stock_d;
      candy_q  <= candy_d;
      busy_q   <= state_d != IDLE;
      sold_q   <= stock_d == '0;
    end
  end
endmodule
